// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard control slice: FSM states, register-zero constant, stage control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   // Memory-wait FSM; ERROR is terminal until reset
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   // x0 is hardwired zero, so a load targeting it never creates a hazard
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Stage enable / flush controls driven into the pipeline registers
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_en;
      logic mem_wb_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                  id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};

   localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_bubble: 1'b1};

   // Shared by memory freeze and ERROR: everything held, NOP into writeback
   localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                     id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_bubble: 1'b1};

   localparam ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};

   localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Latency: count reflects an increment one clock after inc.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Increment on request unless already saturated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: load-use stall, taken-branch flush, data-memory freeze with timeout-to-halt.
// Latency: controls are combinational from state and inputs; state and counters update on the next edge.
// Backpressure: MEM_Ready low freezes the whole pipe; after MEM_TIMEOUT wait cycles the core halts.
module hazard_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_UsesRs1,
   input  logic             ID_UsesRs2,
   input  logic [4:0]       ID_EX_rd,
   input  logic             ID_EX_MemRead,
   input  logic             EX_BranchTaken,
   input  logic             MEM_Req,
   input  logic             MEM_Ready,
   output logic             PC_En,
   output logic             IF_ID_En,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_En,
   output logic             MEM_WB_Bubble,
   output logic             Halted,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushEvents
);

   // Wait counter must be able to hold MEM_TIMEOUT itself
   localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TO_VAL = WCW'(MEM_TIMEOUT);

   state_t         state;
   logic [WCW-1:0] wait_cnt;
   ctrl_t          ctrl;
   logic           freeze;
   logic           load_use;
   logic           flush_apply;
   logic           stall_inc;

   assign freeze = ((state == RUN) && MEM_Req && !MEM_Ready) ||
                   ((state == MEM_WAIT) && !MEM_Ready);

   assign load_use = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                     ((ID_UsesRs1 && (ID_rs1 == ID_EX_rd)) ||
                      (ID_UsesRs2 && (ID_rs2 == ID_EX_rd)));

   // Control selection in priority order: reset, halt, freeze, branch, load-use
   always_comb begin
      ctrl = CTRL_RUN;
      if (!rst_n) begin
         ctrl = CTRL_RESET;
      end else if (state == ERROR) begin
         ctrl = CTRL_FREEZE;
      end else if (freeze) begin
         ctrl = CTRL_FREEZE;
      end else if (EX_BranchTaken) begin
         ctrl = CTRL_FLUSH;
      end else if (load_use) begin
         ctrl = CTRL_LOAD_USE;
      end
   end

   assign PC_En         = ctrl.pc_en;
   assign IF_ID_En      = ctrl.if_id_en;
   assign IF_ID_Flush   = ctrl.if_id_flush;
   assign ID_EX_Flush   = ctrl.id_ex_flush;
   assign EX_MEM_En     = ctrl.ex_mem_en;
   assign MEM_WB_Bubble = ctrl.mem_wb_bubble;
   assign Halted        = (state == ERROR);

   // A branch held in EX during a freeze is only counted when it actually flushes
   assign flush_apply = rst_n && (state != ERROR) && !freeze && EX_BranchTaken;
   assign stall_inc   = rst_n && (state != ERROR) && !ctrl.pc_en;

   // Memory-wait FSM with timeout; wait_cnt saturates when the timeout is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (MEM_Req && !MEM_Ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WCW'(1);
               end
            end
            MEM_WAIT: begin
               if (MEM_Ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if ((MEM_TIMEOUT != 0) && (wait_cnt == TO_VAL)) begin
                  state <= ERROR;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: begin
               state <= ERROR;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (StallCycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_apply),
      .count (FlushEvents)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MEM_TIMEOUT=4, CNT_W=3).
// Latency: inputs driven at negedge, controls checked 1 time unit later, counters checked a cycle on.
// Backpressure: memory freeze and timeout exercised via MEM_Req/MEM_Ready.
module tb_hazard_sequencer;

   localparam int CW = 3;

   // Control vector order: {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_Flush, EX_MEM_En, MEM_WB_Bubble}
   localparam logic [5:0] C_RUN   = 6'b110010;
   localparam logic [5:0] C_RST   = 6'b001101;
   localparam logic [5:0] C_FRZ   = 6'b000001;
   localparam logic [5:0] C_FLUSH = 6'b111110;
   localparam logic [5:0] C_LU    = 6'b000110;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    ID_rs1, ID_rs2, ID_EX_rd;
   logic          ID_UsesRs1, ID_UsesRs2, ID_EX_MemRead, EX_BranchTaken, MEM_Req, MEM_Ready;
   logic          PC_En, IF_ID_En, IF_ID_Flush, ID_EX_Flush, EX_MEM_En, MEM_WB_Bubble, Halted;
   logic [CW-1:0] StallCycles, FlushEvents;
   logic [5:0]    obs;

   int compared   = 0;
   int mismatched = 0;

   assign obs = {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_Flush, EX_MEM_En, MEM_WB_Bubble};

   always #5 clk = ~clk;

   hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ID_rs1         (ID_rs1),
      .ID_rs2         (ID_rs2),
      .ID_UsesRs1     (ID_UsesRs1),
      .ID_UsesRs2     (ID_UsesRs2),
      .ID_EX_rd       (ID_EX_rd),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .EX_BranchTaken (EX_BranchTaken),
      .MEM_Req        (MEM_Req),
      .MEM_Ready      (MEM_Ready),
      .PC_En          (PC_En),
      .IF_ID_En       (IF_ID_En),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_Flush    (ID_EX_Flush),
      .EX_MEM_En      (EX_MEM_En),
      .MEM_WB_Bubble  (MEM_WB_Bubble),
      .Halted         (Halted),
      .StallCycles    (StallCycles),
      .FlushEvents    (FlushEvents)
   );

   task automatic idle();
      ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
      ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0; ID_EX_MemRead = 1'b0;
      EX_BranchTaken = 1'b0; MEM_Req = 1'b0; MEM_Ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      @(negedge clk); #1;
      compared++;
      if (obs !== C_RST) begin mismatched++; $display("FAIL reset_ctrl: got %b want %b", obs, C_RST); end
      compared++;
      if (Halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b want 0", Halted); end
      compared++;
      if (StallCycles !== 3'd0 || FlushEvents !== 3'd0) begin
         mismatched++; $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", StallCycles, FlushEvents);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL idle_ctrl: got %b want %b", obs, C_RUN); end
   endtask

   task automatic test_load_use();
      do_reset();
      ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; ID_rs1 = 5'd5; ID_UsesRs1 = 1'b1;
      #1;
      compared++;
      if (obs !== C_LU) begin mismatched++; $display("FAIL lu_rs1_ctrl: got %b want %b", obs, C_LU); end
      @(negedge clk);
      idle();
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL lu_after_ctrl: got %b want %b", obs, C_RUN); end
      compared++;
      if (StallCycles !== 3'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d want 1", StallCycles); end
      // rd = x0 never stalls
      ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; ID_rs1 = 5'd0; ID_UsesRs1 = 1'b1;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL lu_rd0_ctrl: got %b want %b", obs, C_RUN); end
      // matching register but operand not read: no stall
      ID_EX_rd = 5'd9; ID_rs1 = 5'd9; ID_UsesRs1 = 1'b0;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL lu_unused_ctrl: got %b want %b", obs, C_RUN); end
      // rs2 path
      ID_EX_rd = 5'd7; ID_rs1 = 5'd3; ID_UsesRs1 = 1'b1; ID_rs2 = 5'd7; ID_UsesRs2 = 1'b1;
      #1;
      compared++;
      if (obs !== C_LU) begin mismatched++; $display("FAIL lu_rs2_ctrl: got %b want %b", obs, C_LU); end
      @(negedge clk);
      idle();
      #1;
      compared++;
      if (StallCycles !== 3'd2) begin mismatched++; $display("FAIL lu_stall_cnt2: got %0d want 2", StallCycles); end
   endtask

   task automatic test_branch_vs_load_use();
      do_reset();
      ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; ID_rs1 = 5'd5; ID_UsesRs1 = 1'b1;
      EX_BranchTaken = 1'b1;
      #1;
      compared++;
      if (obs !== C_FLUSH) begin mismatched++; $display("FAIL br_lu_ctrl: got %b want %b", obs, C_FLUSH); end
      @(negedge clk);
      idle();
      #1;
      compared++;
      if (FlushEvents !== 3'd1 || StallCycles !== 3'd0) begin
         mismatched++; $display("FAIL br_lu_counts: got flush=%0d stall=%0d want 1/0", FlushEvents, StallCycles);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      MEM_Req = 1'b1; MEM_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         compared++;
         if (obs !== C_FRZ) begin mismatched++; $display("FAIL mw_freeze%0d: got %b want %b", i, obs, C_FRZ); end
         @(negedge clk);
      end
      MEM_Ready = 1'b1;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL mw_release: got %b want %b", obs, C_RUN); end
      @(negedge clk);
      idle();
      #1;
      compared++;
      if (StallCycles !== 3'd3) begin mismatched++; $display("FAIL mw_stall_cnt: got %0d want 3", StallCycles); end
      // Ready without a request is ignored; the FSM must still be in RUN
      MEM_Ready = 1'b1;
      @(negedge clk);
      MEM_Ready = 1'b0;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL mw_stray_ready: got %b want %b", obs, C_RUN); end
   endtask

   task automatic test_branch_in_freeze();
      do_reset();
      MEM_Req = 1'b1; MEM_Ready = 1'b0; EX_BranchTaken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         compared++;
         if (obs !== C_FRZ) begin mismatched++; $display("FAIL bf_freeze%0d: got %b want %b", i, obs, C_FRZ); end
         @(negedge clk);
      end
      MEM_Ready = 1'b1;
      #1;
      compared++;
      if (obs !== C_FLUSH) begin mismatched++; $display("FAIL bf_release: got %b want %b", obs, C_FLUSH); end
      @(negedge clk);
      idle();
      #1;
      compared++;
      if (FlushEvents !== 3'd1 || StallCycles !== 3'd2) begin
         mismatched++; $display("FAIL bf_counts: got flush=%0d stall=%0d want 1/2", FlushEvents, StallCycles);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      MEM_Req = 1'b1; MEM_Ready = 1'b0;
      // one RUN freeze cycle then four MEM_WAIT cycles before wait_cnt==4 trips
      for (int i = 0; i < 5; i++) begin
         #1;
         compared++;
         if (Halted !== 1'b0 || obs !== C_FRZ) begin
            mismatched++; $display("FAIL to_wait%0d: got halted=%b ctrl=%b want 0/%b", i, Halted, obs, C_FRZ);
         end
         @(negedge clk);
      end
      #1;
      compared++;
      if (Halted !== 1'b1) begin mismatched++; $display("FAIL to_halted: got %b want 1", Halted); end
      MEM_Req = 1'b0; MEM_Ready = 1'b1; EX_BranchTaken = 1'b1;
      #1;
      compared++;
      if (obs !== C_FRZ) begin mismatched++; $display("FAIL to_error_ctrl: got %b want %b", obs, C_FRZ); end
      @(negedge clk);
      #1;
      compared++;
      if (Halted !== 1'b1 || StallCycles !== 3'd5 || FlushEvents !== 3'd0) begin
         mismatched++;
         $display("FAIL to_sticky: got halted=%b stall=%0d flush=%0d want 1/5/0", Halted, StallCycles, FlushEvents);
      end
      idle();
      rst_n = 1'b0;
      #1;
      compared++;
      if (Halted !== 1'b0 || StallCycles !== 3'd0 || obs !== C_RST) begin
         mismatched++; $display("FAIL to_reset: got halted=%b stall=%0d ctrl=%b want 0/0/%b", Halted, StallCycles, obs, C_RST);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL to_run_after: got %b want %b", obs, C_RUN); end
   endtask

   task automatic test_async_reset_mid_wait();
      do_reset();
      MEM_Req = 1'b1; MEM_Ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if (obs !== C_RST || StallCycles !== 3'd0) begin
         mismatched++; $display("FAIL ar_assert: got ctrl=%b stall=%0d want %b/0", obs, StallCycles, C_RST);
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      #1;
      compared++;
      if (obs !== C_RUN) begin mismatched++; $display("FAIL ar_run: got %b want %b", obs, C_RUN); end
   endtask

   task automatic test_saturation();
      do_reset();
      ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd12; ID_rs2 = 5'd12; ID_UsesRs2 = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      #1;
      compared++;
      if (StallCycles !== 3'd6) begin mismatched++; $display("FAIL sat_mid: got %0d want 6", StallCycles); end
      for (int i = 0; i < 4; i++) @(negedge clk);
      #1;
      compared++;
      if (StallCycles !== 3'd7) begin mismatched++; $display("FAIL sat_hold: got %0d want 7", StallCycles); end
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_wait();
      test_branch_in_freeze();
      test_timeout();
      test_async_reset_mid_wait();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline control block for the 5-stage RV32I core. It works alongside the operand forwarding logic: forwarding covers ALU-to-ALU dependencies, and this block handles what forwarding cannot. That means load-use stalls, taken-branch flushes and data-memory wait states. It drives the stage enable and flush controls, contains a memory-wait FSM with a timeout-to-halt, and keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive MEM wait cycles before halting; 0 disables the timeout.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ID_rs1  in  5  rs1 of the instruction in ID
ID_rs2  in  5  rs2 of the instruction in ID
ID_UsesRs1  in  1  instruction in ID reads rs1
ID_UsesRs2  in  1  instruction in ID reads rs2
ID_EX_rd  in  5  rd of the instruction in EX
ID_EX_MemRead  in  1  instruction in EX is a load
EX_BranchTaken  in  1  branch/jump resolved taken in EX
MEM_Req  in  1  load/store active in MEM
MEM_Ready  in  1  data memory completes the access this cycle
PC_En  out  1  PC update enable
IF_ID_En  out  1  IF/ID register enable
IF_ID_Flush  out  1  IF/ID register cleared to NOP
ID_EX_Flush  out  1  ID/EX register cleared to NOP
EX_MEM_En  out  1  ID/EX and EX/MEM register enable
MEM_WB_Bubble  out  1  MEM/WB loads a NOP
Halted  out  1  sticky memory-timeout error
StallCycles  out  CNT_W  cycles with PC_En=0, excluding ERROR
FlushEvents  out  CNT_W  count of applied branch flushes

Behaviour:
- Reset:
  - State=RUN, wait_cnt=0, counters=0, Halted=0.
  - While rst_n=0, all enables are 0, IF_ID_Flush=ID_EX_Flush=1 and MEM_WB_Bubble=1.
- Outputs are combinational from state and inputs. State and counters are registered on the rising edge of clk.
- Default (no event): all enables 1, flushes 0, bubble 0.
- Event priority: memory freeze > branch flush > load-use stall.
- Memory freeze:
  - Condition: (RUN and MEM_Req and !MEM_Ready), or MEM_WAIT with !MEM_Ready.
  - Outputs: PC_En=IF_ID_En=EX_MEM_En=0, MEM_WB_Bubble=1, flushes 0.
  - A taken branch during a freeze is not flushed. EX is held, so EX_BranchTaken persists, and the flush is applied on the release cycle.
- Branch flush: EX_BranchTaken and no freeze gives IF_ID_Flush=ID_EX_Flush=1, PC_En=1 (redirect), IF_ID_En=1. It suppresses any coincident load-use stall.
- Load-use stall:
  - Condition: ID_EX_MemRead and ID_EX_rd!=0 and ((ID_UsesRs1 and ID_rs1==ID_EX_rd) or (ID_UsesRs2 and ID_rs2==ID_EX_rd)).
  - Outputs: PC_En=IF_ID_En=0, ID_EX_Flush=1, EX_MEM_En=1.
  - Lasts exactly 1 cycle; the load then advances.
- FSM states: RUN, MEM_WAIT, ERROR (2-bit encoding).
  - RUN: MEM_Req and !MEM_Ready goes to MEM_WAIT with wait_cnt=1.
  - MEM_WAIT, MEM_Ready=1: release cycle (normal RUN outputs), go to RUN, wait_cnt=0.
  - MEM_WAIT, MEM_Ready=0: wait_cnt++.
  - MEM_WAIT with MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT and !MEM_Ready: go to ERROR.
  - ERROR: all enables 0, MEM_WB_Bubble=1, Halted=1. Only reset exits this state.
- MEM_Ready without MEM_Req in RUN is ignored.
- Counters saturate at all-ones and do not wrap.
  - StallCycles increments in any non-ERROR cycle with PC_En=0.
  - FlushEvents increments in each cycle where the branch flush is applied.
- An async reset mid-wait returns the block to RUN immediately; counters clear.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state typedef: RUN, MEM_WAIT, ERROR.
  - REG_ZERO=5'd0 constant.
  - Control struct type grouping the enable/flush outputs.
- One natural sub-module: sat_counter (parameter CNT_W; ports inc, count), instantiated twice.

Test Plan:
- Load-use:
  - Stimulus: ID_EX_MemRead=1, ID_EX_rd=5, ID_rs1=5, ID_UsesRs1=1.
  - Response: 1 cycle of PC_En=0, IF_ID_En=0, ID_EX_Flush=1. StallCycles goes 0→1. Same stimulus with rd=0 gives no stall.
- Branch versus load-use in the same cycle:
  - Stimulus: both conditions true.
  - Response: IF_ID_Flush=ID_EX_Flush=1, PC_En=1. FlushEvents=1, StallCycles=0.
- Memory wait:
  - Stimulus: MEM_Req=1, MEM_Ready=0 for 3 cycles, then MEM_Ready=1.
  - Response: 3 freeze cycles with MEM_WB_Bubble=1, then release. StallCycles=3, state returns to RUN.
- Branch held during freeze:
  - Stimulus: EX_BranchTaken=1 throughout a 2-cycle wait.
  - Response: no flush during the freeze; flush on the release cycle. FlushEvents=1.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, MEM_Ready held at 0.
  - Response: Halted=1 after wait_cnt reaches 4. Enables stay 0 when MEM_Ready later rises; rst_n pulse clears Halted and counters.
- Saturation:
  - Stimulus: CNT_W=3, 10 stall cycles.
  - Response: StallCycles holds at 7.
